// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage.
//   - ALUCtrl op codes as produced by the ALU control decoder
//   - Execute-stage FSM state encoding
//   - Helper that flags the two op codes the decoder never legitimately emits
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } aluState_e;

  // 011 and 100 have no operation assigned; they still produce a result
  // so the pipeline never waits on them, but the result is flagged.
  function automatic logic isIllegalCode(input logic [2:0] code);
    return (code == 3'b011) || (code == 3'b100);
  endfunction

endpackage

// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per clock.
// Returns the low WIDTH bits of the unsigned product.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-low reset; aborts any operation in flight
//   start_i    load operands and begin (only honoured by the parent when idle)
//   mcand_i    multiplicand
//   mplier_i   multiplier
//   busy_o     an operation is in progress
//   done_o     high during the final iteration cycle; product_o is valid then
//   product_o  accumulator including the final iteration's partial product
module alu_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] accSum;
  logic             lastStep;

  // The product is exposed one cycle early (the sum of the last iteration)
  // so the parent can register it on the same edge the engine finishes.
  assign accSum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign lastStep  = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign busy_o    = busy_q;
  assign done_o    = lastStep;
  assign product_o = accSum;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = accSum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (lastStep) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage. Single-cycle ops (ADD/SUB/AND/OR/SLT and illegal codes)
// produce a registered result one cycle after acceptance; MUL is handed to
// the iterative multiplier and the stage stalls until it finishes.
// Ports:
//   clk_i, rst_i           clock; synchronous active-low reset
//   valid_i / ready_o      request handshake (ready_o is combinational)
//   ALUCtrl_i              op code from the ALU control decoder
//   data1_i, data2_i       operands A and B
//   valid_o / ready_i      result handshake
//   data_o, zero_o         result and its zero flag
//   illegal_o              result came from an unassigned op code
//   stall_o                MUL in progress, for the hazard unit
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic             stall_o
);

  aluState_e        state_q, state_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             accept;
  logic             isMulOp;
  logic             mulStart;
  logic             mulBusy;
  logic             mulDone;
  logic [WIDTH-1:0] mulProduct;
  logic [WIDTH-1:0] aluResult;
  logic             aluIllegal;

  // A held result blocks acceptance unless it drains in this same cycle.
  assign ready_o   = (state_q == IDLE) && (!valid_q || ready_i);
  assign accept    = valid_i && ready_o;
  assign isMulOp   = (ALUCtrl_i == ALU_MUL);
  assign mulStart  = accept && isMulOp;
  assign stall_o   = (state_q == MUL);
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

  alu_seq_multiplier #(
    .WIDTH(WIDTH)
  ) uMultiplier (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mulStart),
    .mcand_i  (data1_i),
    .mplier_i (data2_i),
    .busy_o   (mulBusy),
    .done_o   (mulDone),
    .product_o(mulProduct)
  );

  always_comb begin
    aluResult  = '0;
    aluIllegal = isIllegalCode(ALUCtrl_i);
    case (ALUCtrl_i)
      ALU_ADD: aluResult = data1_i + data2_i;
      ALU_SUB: aluResult = data1_i - data2_i;
      ALU_AND: aluResult = data1_i & data2_i;
      ALU_OR:  aluResult = data1_i | data2_i;
      ALU_SLT: aluResult = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      default: aluResult = '0;
    endcase
  end

  // The engine not being busy while in MUL cannot happen after a clean
  // reset; falling back to IDLE keeps the stage from stalling forever.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mulStart) state_d = MUL;
      MUL: begin
        if (mulDone) begin
          state_d = DONE;
        end else if (!mulBusy) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new result loaded on the same edge overrides the drain.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (accept && !isMulOp) begin
      valid_d   = 1'b1;
      data_d    = aluResult;
      zero_d    = (aluResult == '0);
      illegal_d = aluIllegal;
    end else if (mulDone) begin
      valid_d   = 1'b1;
      data_d    = mulProduct;
      zero_d    = (mulProduct == '0);
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      data_q    <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a transaction-level
// reference model.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             illegal_o;
  logic             stall_o;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          modelKnown = 1'b0;
  logic        mValid;
  logic        mZero;
  logic        mIllegal;
  logic [31:0] mData;
  logic [31:0] mPending;
  int          mBusy;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ALUCtrl_i(ALUCtrl_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .zero_o   (zero_o),
    .illegal_o(illegal_o),
    .stall_o  (stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Result of an op straight from the instruction-set definition.
  function automatic logic [31:0] refResult(input logic [2:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] wide;
    case (code)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101: begin
        wide = 64'(a) * 64'(b);
        return wide[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, compares every output with the model before
  // the edge, then advances the model across the edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [2:0] code,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic rdy);
    logic expReady;
    rst_i     = rst;
    valid_i   = v;
    ALUCtrl_i = code;
    data1_i   = a;
    data2_i   = b;
    ready_i   = rdy;
    #1;
    expReady = (mBusy == 0) && (!mValid || rdy);
    if (modelKnown) begin
      checkOutput("ready_o", 32'(ready_o), 32'(expReady));
      checkOutput("stall_o", 32'(stall_o), 32'(mBusy > 1));
      checkOutput("valid_o", 32'(valid_o), 32'(mValid));
      checkOutput("data_o", data_o, mData);
      checkOutput("zero_o", 32'(zero_o), 32'(mZero));
      checkOutput("illegal_o", 32'(illegal_o), 32'(mIllegal));
    end
    @(posedge clk_i);
    if (!rst) begin
      modelKnown = 1'b1;
      mValid     = 1'b0;
      mData      = 32'd0;
      mZero      = 1'b0;
      mIllegal   = 1'b0;
      mBusy      = 0;
      mPending   = 32'd0;
    end else if (modelKnown) begin
      if (mValid && rdy) mValid = 1'b0;
      if (mBusy == 2) begin
        mValid   = 1'b1;
        mData    = mPending;
        mZero    = (mPending == 32'd0);
        mIllegal = 1'b0;
      end
      if (mBusy > 0) mBusy--;
      if (v && expReady) begin
        if (code == 3'b101) begin
          mBusy    = WIDTH + 1;
          mPending = refResult(code, a, b);
        end else begin
          mValid   = 1'b1;
          mData    = refResult(code, a, b);
          mZero    = (mData == 32'd0);
          mIllegal = (code == 3'b011) || (code == 3'b100);
        end
      end
    end
    #1;
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b1, 1'b0, 3'($urandom), $urandom, $urandom, rdy);
  endtask

  initial begin
    logic [2:0]  rCode;
    logic [31:0] rA;
    logic [31:0] rB;

    $display("[TB] reset with random inputs");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom));
    end
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_data", data_o, 32'd0);
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    #1;
    checkOutput("reset_ready", 32'(ready_o), 32'd1);

    $display("[TB] ADD then SUB back to back");
    applyStimulus(1'b1, 1'b1, 3'b010, 32'd7, 32'd5, 1'b1);
    checkOutput("add_data", data_o, 32'd12);
    checkOutput("add_zero", 32'(zero_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 3'b110, 32'd5, 32'd5, 1'b1);
    checkOutput("sub_data", data_o, 32'd0);
    checkOutput("sub_zero", 32'(zero_o), 32'd1);
    checkOutput("sub_valid", 32'(valid_o), 32'd1);

    $display("[TB] SLT signed and ADD wrap");
    applyStimulus(1'b1, 1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1);
    checkOutput("slt_data", data_o, 32'd1);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1, 1'b1);
    checkOutput("wrap_data", data_o, 32'd0);
    checkOutput("wrap_zero", 32'(zero_o), 32'd1);

    $display("[TB] MUL 6*7 latency");
    applyStimulus(1'b1, 1'b1, 3'b101, 32'd6, 32'd7, 1'b1);
    checkOutput("mul_stall_first", 32'(stall_o), 32'd1);
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(1'b1, 1'b1, 3'b010, $urandom, $urandom, 1'b1);
    end
    checkOutput("mul_valid", 32'(valid_o), 32'd1);
    checkOutput("mul_data", data_o, 32'd42);
    checkOutput("mul_stall_end", 32'(stall_o), 32'd0);
    idleCycle(1'b1);

    $display("[TB] MUL overflow to zero");
    applyStimulus(1'b1, 1'b1, 3'b101, 32'h0001_0000, 32'h0001_0000, 1'b1);
    for (int i = 0; i < WIDTH; i++) idleCycle(1'b1);
    checkOutput("mul_big_valid", 32'(valid_o), 32'd1);
    checkOutput("mul_big_data", data_o, 32'd0);
    idleCycle(1'b1);

    $display("[TB] backpressure hold");
    applyStimulus(1'b1, 1'b1, 3'b001, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 3'b010, $urandom, $urandom, 1'b0);
      checkOutput("bp_data", data_o, 32'h0000_00FF);
      checkOutput("bp_valid", 32'(valid_o), 32'd1);
    end
    idleCycle(1'b1);
    checkOutput("bp_drained", 32'(valid_o), 32'd0);

    $display("[TB] reset during MUL, then illegal code");
    applyStimulus(1'b1, 1'b1, 3'b101, 32'd123, 32'd456, 1'b1);
    for (int i = 0; i < 9; i++) idleCycle(1'b1);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b1);
    checkOutput("abort_stall", 32'(stall_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 3'b100, $urandom, $urandom, 1'b0);
    checkOutput("illegal_valid", 32'(valid_o), 32'd1);
    checkOutput("illegal_flag", 32'(illegal_o), 32'd1);
    checkOutput("illegal_data", data_o, 32'd0);
    checkOutput("illegal_zero", 32'(zero_o), 32'd1);
    for (int i = 0; i < WIDTH + 4; i++) idleCycle(1'b1);
    checkOutput("abort_no_result", 32'(valid_o), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 700; i++) begin
      rCode = 3'($urandom);
      rA    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rB    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 7), rCode, rA, rB,
                    ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
